servo_deadtime: RTL
===================

# servo_deadtime

Three-phase dead-time inserter and fault gate sitting directly downstream of the servo PWM modulator. It takes the modulator's raw per-phase upper and lower drive requests and produces the gate-driver signals. It guarantees that the upper and lower switch of a phase are never on together, and holds both switches low for a programmable dead time whenever a phase hands over. An external fault input latches all outputs low until software clears the fault. Configuration uses the same Avalon-MM slave style as the modulator.

## Interface
- `DT_WIDTH`, 8: width of the dead-time count register.
- `DT_RESET`, 10: dead-time value loaded at reset, in clk cycles.
- `clk` in 1: single clock, shared with the modulator.
- `reset` in 1: synchronous, active-high reset.
- `MMS_addr` in 2: Avalon slave address.
- `MMS_write` in 1: Avalon write strobe.
- `MMS_writedata` in 32: Avalon write data.
- `Udrive_in` in [0:2]: raw upper-switch requests from the modulator.
- `Ldrive_in` in [0:2]: raw lower-switch requests from the modulator.
- `fault_n` in 1: external fault, active low, asynchronous to clk.
- `Uout` out [0:2]: gated upper-switch drive, registered.
- `Lout` out [0:2]: gated lower-switch drive, registered.
- `fault_irq` out 1: one-cycle pulse when the fault latch sets and the IRQ is enabled.
- `fault_active` out 1: current value of the fault latch.

## Operation
- Register map (writes only; all fields sample `MMS_writedata` LSBs):
  - 0: `dt[DT_WIDTH-1:0]`.
  - 1: `enable` (bit0).
  - 2: fault clear (write 1 to bit0).
  - 3: `irq_en` (bit0).
- Reset values:
  - `dt = DT_RESET`; `enable`, fault latch and `irq_en` = 0.
  - All `Uout`/`Lout`, `fault_irq` and `fault_active` = 0.
  - Every phase FSM = OFF with its off counter saturated (all ones).
- Per-phase request decode:
  - U request = `Udrive_in & ~Ldrive_in`.
  - L request = `Ldrive_in & ~Udrive_in`.
  - Both high or both low = no request.
- Per-phase FSM has three states: OFF (both low), U_ON, L_ON.
  - U_ON or L_ON → OFF on the first edge where the matching request is absent. The off counter clears to 0.
  - OFF: the off counter increments each cycle and saturates at all ones.
  - OFF → U_ON / L_ON when the request is present and `off_cnt + 1 >= max(dt,1)`.
  - Direct U_ON ↔ L_ON is illegal. At least one OFF cycle is always inserted.
- `enable = 0`: all phases held in OFF and outputs low. Off counters keep counting.
- Fault:
  - Synchronised `fault_n` low sets the latch. At the next edge all FSMs are forced to OFF with counters cleared.
  - The latch holds while `fault_n` is low, regardless of other inputs.
  - Clear write takes effect only if synchronised `fault_n` is high in that cycle; otherwise it is ignored.
  - Fault asserting in the same cycle as a clear write: the fault wins.
- `dt` written mid-operation: applies from the next cycle to any phase currently in OFF. Phases that are on are unaffected.

## Timing
- Turn-off latency: request drop → output low at the first edge (1 cycle).
- Handover with a steady opposite request: both outputs low for exactly `max(dt,1)` cycles.
- First turn-on after reset, with `enable = 1` and a request: 1 cycle, because the counter is saturated.
- Fault path:
  - Synchronised fault → outputs low at the next edge.
  - `fault_irq` pulses in the same cycle that `fault_active` rises.
  - Fault latency from `fault_n` pin: 3 cycles with synchroniser, 1 cycle without.
- Register writes take effect on the cycle after the write.
- Reset asserted mid-operation: all outputs low on the next edge and the register file returns to reset values.

## Configuration
- `SERVO_DT_FAULT_SYNC_EN`
  - Defined: `fault_n` passes through a 2-flop synchroniser before the latch.
  - Undefined: `fault_n` feeds the latch logic directly, for use when the fault is already synchronous to clk.

## Structure
- Package `servo_dt_pkg`:
  - Phase state enum (OFF, U_ON, L_ON).
  - Register address constants `DT_ADDR_DT`, `DT_ADDR_EN`, `DT_ADDR_CLR`, `DT_ADDR_IRQEN`.
- Sub-module `servo_dt_phase`, instantiated 3 times. Each instance contains one FSM, its off counter and its registered outputs.
- The top level holds the register file, fault synchroniser/latch and IRQ.

## Test plan
- **Handover:** reset, `dt = 5`, enable; Udrive=1 then switch to Ldrive=1 → Uout falls after 1 cycle, both low exactly 5 cycles, then Lout rises and stays high.
- **Zero dead time:** `dt = 0`, toggle U→L → exactly 1 cycle with both low.
- **Illegal request:** Udrive=Ldrive=1 on phase 1 while phase 1 is in U_ON → phase 1 goes to OFF and stays low; phases 0 and 2 are unaffected.
- **Fault:** `irq_en = 1`, pull `fault_n` low mid-pulse → outputs low, `fault_irq` high for 1 cycle, `fault_active = 1`.
  - Clear written while `fault_n` is still low → ignored.
  - Release `fault_n`, then clear → `fault_active = 0`; outputs resume after `max(dt,1)` cycles.
- **Disable/enable:** `enable = 0` with active requests → all outputs 0. Re-enable after more than `dt` cycles → outputs follow the requests 1 cycle later.
- **Reset mid-run:** assert `reset` for 1 cycle while Uout=1 → all outputs 0 and `dt` reads back as `DT_RESET` behaviour (10-cycle handover).

Source files
------------

// File: rtl/servo_dt_pkg.sv
// servo_dt_pkg: definitions shared by the servo dead-time inserter.
//   phase_state_e : per-phase switch state (both off, upper on, lower on)
//   DT_ADDR_*     : Avalon-MM register addresses
package servo_dt_pkg;

    typedef enum logic [1:0] {
        PH_OFF  = 2'd0,
        PH_U_ON = 2'd1,
        PH_L_ON = 2'd2
    } phase_state_e;

    localparam logic [1:0] DT_ADDR_DT    = 2'd0;
    localparam logic [1:0] DT_ADDR_EN    = 2'd1;
    localparam logic [1:0] DT_ADDR_CLR   = 2'd2;
    localparam logic [1:0] DT_ADDR_IRQEN = 2'd3;

endpackage

// File: rtl/servo_dt_phase.sv
// servo_dt_phase: dead-time FSM for one inverter leg.
//   clk, reset        : clock, synchronous active-high reset
//   enable            : 0 holds the leg off (the off counter keeps running)
//   force_off         : fault, forces OFF and holds the off counter at zero
//   dt                : minimum number of both-off cycles before a turn-on
//   u_drive, l_drive  : raw upper/lower requests from the modulator
//   u_out, l_out      : registered gate drives
module servo_dt_phase
    import servo_dt_pkg::*;
#(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                force_off,
    input  logic [DT_WIDTH-1:0] dt,
    input  logic                u_drive,
    input  logic                l_drive,
    output logic                u_out,
    output logic                l_out
);

    phase_state_e        state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                u_q, u_d;
    logic                l_q, l_d;

    logic                u_req, l_req;
    logic [DT_WIDTH-1:0] dt_eff;
    logic [DT_WIDTH:0]   cnt_inc;
    logic                gap_ok;

    // Both requests high is contradictory and treated as "no request".
    assign u_req   = u_drive & ~l_drive;
    assign l_req   = l_drive & ~u_drive;
    // A zero dead time still leaves one OFF cycle between the switches.
    assign dt_eff  = (dt == '0) ? DT_WIDTH'(1) : dt;
    // One bit wider so a saturated counter never wraps in the compare.
    assign cnt_inc = {1'b0, cnt_q} + (DT_WIDTH + 1)'(1);
    assign gap_ok  = cnt_inc >= {1'b0, dt_eff};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_off) begin
            state_d = PH_OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                PH_OFF: begin
                    if (enable && u_req && gap_ok) begin
                        state_d = PH_U_ON;
                    end else if (enable && l_req && gap_ok) begin
                        state_d = PH_L_ON;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + DT_WIDTH'(1);
                    end
                end
                PH_U_ON: begin
                    // Always via OFF, never straight to the other switch.
                    if (!enable || !u_req) begin
                        state_d = PH_OFF;
                        cnt_d   = '0;
                    end
                end
                PH_L_ON: begin
                    if (!enable || !l_req) begin
                        state_d = PH_OFF;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = PH_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
        u_d = (state_d == PH_U_ON);
        l_d = (state_d == PH_L_ON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PH_OFF;
            cnt_q   <= '1;
            u_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            u_q     <= u_d;
            l_q     <= l_d;
        end
    end

    assign u_out = u_q;
    assign l_out = l_q;

endmodule

// File: rtl/servo_deadtime.sv
// servo_deadtime: three-phase dead-time inserter and fault gate.
//   clk, reset           : clock, synchronous active-high reset
//   MMS_addr/write/data  : Avalon-MM write-only register port
//                          0 dt, 1 enable, 2 fault clear, 3 irq_en
//   Udrive_in, Ldrive_in : raw per-phase requests from the modulator
//   fault_n              : external fault, active low
//   Uout, Lout           : registered, dead-time-gated gate drives
//   fault_irq            : one-cycle pulse when the fault latch sets (irq_en=1)
//   fault_active         : fault latch state
// Build option SERVO_DT_FAULT_SYNC_EN: when defined fault_n goes through a
// 2-flop synchroniser; otherwise it is assumed synchronous to clk.
module servo_deadtime
    import servo_dt_pkg::*;
#(
    parameter int DT_WIDTH = 8,
    parameter int DT_RESET = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  MMS_addr,
    input  logic        MMS_write,
    input  logic [31:0] MMS_writedata,
    input  logic [0:2]  Udrive_in,
    input  logic [0:2]  Ldrive_in,
    input  logic        fault_n,
    output logic [0:2]  Uout,
    output logic [0:2]  Lout,
    output logic        fault_irq,
    output logic        fault_active
);

    logic [DT_WIDTH-1:0] dt_q, dt_d;
    logic                en_q, en_d;
    logic                irq_en_q, irq_en_d;
    logic                fault_q, fault_d;
    logic                irq_q, irq_d;

    logic                fault_s;
    logic                fault_set;
    logic                clr_req;
    logic                force_off;
    logic                unused_wd;

    assign unused_wd = &{1'b0, MMS_writedata[31:DT_WIDTH]};

`ifdef SERVO_DT_FAULT_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= fault_n;
            sync2_q <= sync1_q;
        end
    end

    assign fault_s = sync2_q;
`else
    assign fault_s = fault_n;
`endif

    always_comb begin
        dt_d      = dt_q;
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        fault_set = ~fault_s;
        clr_req   = MMS_write && (MMS_addr == DT_ADDR_CLR) && MMS_writedata[0];
        if (MMS_write && (MMS_addr == DT_ADDR_DT))    dt_d     = MMS_writedata[DT_WIDTH-1:0];
        if (MMS_write && (MMS_addr == DT_ADDR_EN))    en_d     = MMS_writedata[0];
        if (MMS_write && (MMS_addr == DT_ADDR_IRQEN)) irq_en_d = MMS_writedata[0];
        // An active fault overrides a clear in the same cycle.
        fault_d   = fault_set | (fault_q & ~clr_req);
        irq_d     = fault_d & ~fault_q & irq_en_q;
        // The raw fault term kills the outputs on the very next edge; the
        // latched term keeps counters at zero until one cycle after a clear,
        // so restart always waits a full dead time.
        force_off = fault_set | fault_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dt_q     <= DT_WIDTH'(DT_RESET);
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            fault_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            dt_q     <= dt_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            fault_q  <= fault_d;
            irq_q    <= irq_d;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_phase
        servo_dt_phase #(
            .DT_WIDTH (DT_WIDTH)
        ) u_phase (
            .clk       (clk),
            .reset     (reset),
            .enable    (en_q),
            .force_off (force_off),
            .dt        (dt_q),
            .u_drive   (Udrive_in[gi]),
            .l_drive   (Ldrive_in[gi]),
            .u_out     (Uout[gi]),
            .l_out     (Lout[gi])
        );
    end

    assign fault_irq    = irq_q;
    assign fault_active = fault_q;

endmodule
